edge_detect_multi: RTL and testbench

- Multi-channel successor to the single-channel edge detector.
- Each channel of `rx_int` passes through a synchroniser and a debounce filter. Rising, falling and both-edge pulses are then detected on the filtered level.
- Each channel latches a sticky interrupt-pending flag for the edge type its mode selects; the flags are OR-ed into one `irq`.
- Sits between asynchronous external interrupt pins and the interrupt/status logic in the `clk_50M` domain.

---
 rtl/edge_detect_multi.sv | 173 +++++++++++++++++
 tb/tb_edge_detect_multi.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detect_multi.sv
// edge_detect_multi
// Multi-channel interrupt edge detector. Each channel of rx_int goes through
// a flop synchroniser and a debounce filter; registered rising/falling/both
// pulses are produced from the filtered level. A per-channel sticky pending
// flag is set for the edge type selected by mode and cleared by irq_clr
// (set wins over clear). irq is the OR of all pending flags.
//
// Optional feature, enabled by defining the macro EDGE_CNT_EN:
//   adds cnt_clr / edge_cnt and one saturating event counter per channel.
//
// rst_n asserts asynchronously; its deassertion is expected to be aligned to
// clk_50M by the system reset synchroniser that drives it.
module edge_detect_multi #(
  parameter int CH_NUM      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  input  logic [CH_NUM-1:0]       rx_int,
  input  logic [2*CH_NUM-1:0]     mode,
  input  logic [CH_NUM-1:0]       irq_clr,
`ifdef EDGE_CNT_EN
  input  logic [CH_NUM-1:0]       cnt_clr,
  output logic [CH_NUM*CNT_W-1:0] edge_cnt,
`endif
  output logic [CH_NUM-1:0]       pos_rx_int,
  output logic [CH_NUM-1:0]       neg_rx_int,
  output logic [CH_NUM-1:0]       doub_rx_int,
  output logic [CH_NUM-1:0]       irq_pend,
  output logic                    irq
);

  // Filter counter only has to reach FILT_LEN-1.
  localparam int              FC_W    = $clog2(FILT_LEN + 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_LEN - 1);

  // Reject illegal configurations at elaboration time.
  if ((CH_NUM < 1) || (CH_NUM > 32) || (SYNC_STAGES < 2) || (SYNC_STAGES > 4) ||
      (FILT_LEN < 1) || (FILT_LEN > 255) || (CNT_W < 1)) begin : g_bad_param
    $error("edge_detect_multi: parameter out of range");
  end

  logic [CH_NUM-1:0] w_pos;
  logic [CH_NUM-1:0] w_neg;
  logic [CH_NUM-1:0] w_doub;
  logic [CH_NUM-1:0] w_pend;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [FC_W-1:0]        r_fc;
    logic                   r_pos;
    logic                   r_neg;
    logic                   r_doub;
    logic                   r_pend;
    logic                   w_s;
    logic                   w_filt_nxt;
    logic [FC_W-1:0]        w_fc_nxt;
    logic                   w_set;
    logic [1:0]             w_mode;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_mode = mode[2*gi +: 2];

    // Shift the raw asynchronous input through the synchroniser chain.
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], rx_int[gi]};
      end
    end

    // Debounce: accept the synchronised level only after FILT_LEN
    // consecutive samples that differ from the current filtered level.
    always_comb begin
      w_filt_nxt = r_filt;
      w_fc_nxt   = r_fc;
      if (w_s == r_filt) begin
        w_fc_nxt = '0;
      end else if (r_fc == FC_LAST) begin
        w_filt_nxt = w_s;
        w_fc_nxt   = '0;
      end else begin
        w_fc_nxt = r_fc + FC_W'(1);
      end
    end

    // Filter state and registered edge pulses from the filtered level.
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        r_filt   <= 1'b0;
        r_filt_d <= 1'b0;
        r_fc     <= '0;
        r_pos    <= 1'b0;
        r_neg    <= 1'b0;
        r_doub   <= 1'b0;
      end else begin
        r_filt   <= w_filt_nxt;
        r_filt_d <= r_filt;
        r_fc     <= w_fc_nxt;
        r_pos    <= r_filt & ~r_filt_d;
        r_neg    <= ~r_filt & r_filt_d;
        r_doub   <= r_filt ^ r_filt_d;
      end
    end

    // Decide whether this cycle's pulse should raise the pending flag.
    always_comb begin
      w_set = 1'b0;
      case (w_mode)
        2'b01:   w_set = r_pos;
        2'b10:   w_set = r_neg;
        2'b11:   w_set = r_pos | r_neg;
        default: w_set = 1'b0;
      endcase
    end

    // Sticky pending flag; a new event beats a simultaneous clear.
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        r_pend <= 1'b0;
      end else if (w_set) begin
        r_pend <= 1'b1;
      end else if (irq_clr[gi]) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= r_pend;
      end
    end

`ifdef EDGE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    logic [CNT_W-1:0] r_cnt;

    // Saturating event counter; a clear coinciding with an event leaves 1.
    always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
      end else if (w_set) begin
        if (cnt_clr[gi]) begin
          r_cnt <= CNT_W'(1);
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_cnt <= r_cnt;
        end
      end else if (cnt_clr[gi]) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt;
      end
    end

    assign edge_cnt[CNT_W*gi +: CNT_W] = r_cnt;
`endif

    assign w_pos[gi]  = r_pos;
    assign w_neg[gi]  = r_neg;
    assign w_doub[gi] = r_doub;
    assign w_pend[gi] = r_pend;
  end

  assign pos_rx_int  = w_pos;
  assign neg_rx_int  = w_neg;
  assign doub_rx_int = w_doub;
  assign irq_pend    = w_pend;
  assign irq         = |w_pend;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Testbench for edge_detect_multi: directed scenarios followed by random
// traffic, all outputs compared every cycle with a behavioural model.
module tb_edge_detect_multi;
  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int FL  = 4;
  localparam int LAT = SS + FL + 1;
`ifdef EDGE_CNT_EN
  localparam int CW  = 2;
`endif

  logic            clk_50M = 1'b0;
  logic            rst_n   = 1'b1;
  logic [CH-1:0]   rx_int  = '0;
  logic [2*CH-1:0] mode    = '0;
  logic [CH-1:0]   irq_clr = '0;
  logic [CH-1:0]   pos_rx_int, neg_rx_int, doub_rx_int, irq_pend;
  logic            irq;
`ifdef EDGE_CNT_EN
  logic [CH-1:0]    cnt_clr = '0;
  logic [CH*CW-1:0] edge_cnt;
`endif

  int n_checks;
  int n_pass;

  always #10 clk_50M = ~clk_50M;

  edge_detect_multi #(
    .CH_NUM(CH), .SYNC_STAGES(SS), .FILT_LEN(FL)
`ifdef EDGE_CNT_EN
    , .CNT_W(CW)
`endif
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .rx_int(rx_int), .mode(mode),
    .irq_clr(irq_clr),
`ifdef EDGE_CNT_EN
    .cnt_clr(cnt_clr), .edge_cnt(edge_cnt),
`endif
    .pos_rx_int(pos_rx_int), .neg_rx_int(neg_rx_int),
    .doub_rx_int(doub_rx_int), .irq_pend(irq_pend), .irq(irq)
  );

  // ---------------- behavioural model ----------------
  logic [CH-1:0] m_samples[$];   // raw samples still in flight to the filter
  logic [CH-1:0] m_lvl, m_lvl_prev, m_pos, m_neg, m_pend;
  int            m_streak[CH];   // consecutive samples differing from m_lvl
`ifdef EDGE_CNT_EN
  int            m_cnt[CH];
`endif

  task automatic model_reset();
    m_samples.delete();
    for (int k = 0; k < SS; k++) m_samples.push_back('0);
    m_lvl = '0; m_lvl_prev = '0; m_pos = '0; m_neg = '0; m_pend = '0;
    for (int c = 0; c < CH; c++) begin
      m_streak[c] = 0;
`ifdef EDGE_CNT_EN
      m_cnt[c] = 0;
`endif
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] seen;
    logic [1:0]    md;
    bit            ev;
    seen = m_samples[0];
    for (int c = 0; c < CH; c++) begin
      md = mode[2*c +: 2];
      ev = (md == 2'd1 && m_pos[c]) || (md == 2'd2 && m_neg[c]) ||
           (md == 2'd3 && (m_pos[c] || m_neg[c]));
      if (ev) m_pend[c] = 1'b1;
      else if (irq_clr[c]) m_pend[c] = 1'b0;
`ifdef EDGE_CNT_EN
      if (ev) m_cnt[c] = cnt_clr[c] ? 1 : ((m_cnt[c] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt[c] + 1);
      else if (cnt_clr[c]) m_cnt[c] = 0;
`endif
    end
    m_pos = m_lvl & ~m_lvl_prev;
    m_neg = ~m_lvl & m_lvl_prev;
    m_lvl_prev = m_lvl;
    for (int c = 0; c < CH; c++) begin
      if (seen[c] == m_lvl[c]) m_streak[c] = 0;
      else begin
        m_streak[c]++;
        if (m_streak[c] == FL) begin
          m_lvl[c] = seen[c];
          m_streak[c] = 0;
        end
      end
    end
    m_samples.push_back(rx_int);
    void'(m_samples.pop_front());
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("pos_rx_int", 32'(pos_rx_int), 32'(m_pos));
    chk("neg_rx_int", 32'(neg_rx_int), 32'(m_neg));
    chk("doub_rx_int", 32'(doub_rx_int), 32'(m_pos | m_neg));
    chk("irq_pend", 32'(irq_pend), 32'(m_pend));
    chk("irq", 32'(irq), 32'(|m_pend));
`ifdef EDGE_CNT_EN
    for (int c = 0; c < CH; c++) chk($sformatf("edge_cnt%0d", c), 32'(edge_cnt[CW*c +: CW]), 32'(m_cnt[c]));
`endif
  endtask

  task automatic tick();
    @(posedge clk_50M);
    if (!rst_n) model_reset();
    else model_edge();
    @(negedge clk_50M);
    check_all();
  endtask

  task automatic run_count(input int ch, input int cycles,
                           output int fp, output int np, output int fn, output int nn);
    fp = 0; np = 0; fn = 0; nn = 0;
    for (int k = 1; k <= cycles; k++) begin
      tick();
      if (pos_rx_int[ch]) begin np++; if (fp == 0) fp = k; end
      if (neg_rx_int[ch]) begin nn++; if (fn == 0) fn = k; end
    end
  endtask

  task automatic wait_edge(input int ch, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (pos_rx_int[ch] || neg_rx_int[ch]) found = 1'b1;
    end
    chk(tag, 32'(found), 32'd1);
  endtask

  int fp, np, fn, nn, acc_p, acc_n, npulse;
  logic irq_seen;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();

    // Reset: everything low while rst_n is asserted.
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;

    // ch0, mode 11: rise then fall, latency and width of each pulse.
    mode[1:0] = 2'b11;
    rx_int[0] = 1'b1;
    run_count(0, 20, fp, np, fn, nn);
    chk("rise_latency", 32'(fp), 32'(LAT));
    chk("rise_width", 32'(np), 32'd1);
    chk("rise_no_neg", 32'(nn), 32'd0);
    chk("pend0_set", 32'(irq_pend[0]), 32'd1);
    chk("irq_set", 32'(irq), 32'd1);
    rx_int[0] = 1'b0;
    run_count(0, 20, fp, np, fn, nn);
    chk("fall_latency", 32'(fn), 32'(LAT));
    chk("fall_width", 32'(nn), 32'd1);
    chk("fall_no_pos", 32'(np), 32'd0);

    // ch1: a 3-cycle glitch is swallowed, a 4-cycle pulse passes.
    mode[3:2] = 2'b11;
    rx_int[1] = 1'b1;
    run_count(1, FL - 1, fp, acc_p, fn, acc_n);
    rx_int[1] = 1'b0;
    run_count(1, 16, fp, np, fn, nn);
    chk("glitch_pulses", 32'(acc_p + acc_n + np + nn), 32'd0);
    chk("glitch_pend1", 32'(irq_pend[1]), 32'd0);
    rx_int[1] = 1'b1;
    run_count(1, FL, fp, acc_p, fn, acc_n);
    rx_int[1] = 1'b0;
    run_count(1, 16, fp, np, fn, nn);
    chk("min_pulse_pos", 32'(acc_p + np), 32'd1);
    chk("min_pulse_neg", 32'(acc_n + nn), 32'd1);

    // ch2, mode 01: toggling, set-vs-clear priority, later clear.
    mode[5:4] = 2'b01;
    irq_clr = '1;
    tick();
    irq_clr = '0;
    for (int t = 0; t < 6; t++) begin
      rx_int[2] = ~rx_int[2];
      repeat (8) tick();
    end
    irq_clr = '1;
    tick();
    irq_clr = '0;
    rx_int[2] = 1'b1;
    wait_edge(2, "wait_rise2");
    irq_clr[2] = 1'b1;
    tick();
    irq_clr[2] = 1'b0;
    chk("set_beats_clr", 32'(irq_pend[2]), 32'd1);
    rx_int[2] = 1'b0;
    repeat (12) tick();
    chk("fall_ignored2", 32'(irq_pend[2]), 32'd1);
    irq_clr = '1;
    tick();
    irq_clr = '0;
    chk("clr_pend2", 32'(irq_pend[2]), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);

    // All channels mode 00 toggling: pulses but no pending.
    mode = '0;
    npulse = 0;
    irq_seen = 1'b0;
    for (int t = 0; t < 6; t++) begin
      rx_int = ~rx_int;
      repeat (6) begin
        tick();
        npulse += $countones(pos_rx_int | neg_rx_int);
        irq_seen |= irq;
      end
    end
    repeat (10) begin
      tick();
      npulse += $countones(pos_rx_int | neg_rx_int);
      irq_seen |= irq;
    end
    chk("off_pulses", 32'(npulse), 32'(6 * CH));
    chk("off_pend", 32'(irq_pend), 32'd0);
    chk("off_irq_seen", 32'(irq_seen), 32'd0);

    // ch3: reset during filtering discards the transition.
    rx_int = '0;
    mode[7:6] = 2'b11;
    repeat (12) tick();
    rx_int[3] = 1'b1;
    repeat (SS + 2) tick();
    rst_n = 1'b0;
    rx_int[3] = 1'b0;
    #1 model_reset();
    check_all();
    tick();
    tick();
    rst_n = 1'b1;
    run_count(3, 14, fp, np, fn, nn);
    chk("rst_mid_pulses", 32'(np + nn), 32'd0);

`ifdef EDGE_CNT_EN
    // Counter saturation and clear-with-event.
    mode[1:0] = 2'b11;
    cnt_clr[0] = 1'b1;
    tick();
    cnt_clr[0] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      rx_int[0] = ~rx_int[0];
      repeat (8) tick();
    end
    chk("cnt_saturate", 32'(edge_cnt[CW-1:0]), 32'd3);
    rx_int[0] = ~rx_int[0];
    wait_edge(0, "wait_edge0");
    cnt_clr[0] = 1'b1;
    tick();
    cnt_clr[0] = 1'b0;
    chk("cnt_clr_edge", 32'(edge_cnt[CW-1:0]), 32'd1);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) rx_int[c] = ~rx_int[c];
        if ($urandom_range(0, 31) == 0) mode[2*c +: 2] = 2'($urandom_range(0, 3));
        irq_clr[c] = ($urandom_range(0, 7) == 0);
`ifdef EDGE_CNT_EN
        cnt_clr[c] = ($urandom_range(0, 15) == 0);
`endif
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
